// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and constants for the score register file port arbiter.
package regfile_port_arbiter_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INCR  = 2'b10;

  // Requester 1 is read-only and op 11 is a read, so both collapse to OP_READ.
  function automatic logic [1:0] norm_op(input logic owner, input logic [1:0] op);
    if (owner || op == 2'b11) return OP_READ;
    return op;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick2.sv
// Two-input round-robin picker: one-hot winner, the requester not served last wins a tie.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // On contention grant the other requester; otherwise pass the lone request through.
  always_comb begin
    o_grant = i_req;
    if (&i_req) o_grant = i_last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the score register file's read port P and write port between the
// game controller (req 0) and the read-only display scanner (req 1).
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        reqValid,
  input  logic [1:0]        reqOp0,
  input  logic [1:0]        reqOp1,
  input  logic [ADDR_W-1:0] reqAddr0,
  input  logic [ADDR_W-1:0] reqAddr1,
  input  logic [DATA_W-1:0] reqData0,
  input  logic [DATA_W-1:0] reqData1,
  output logic [1:0]        accept,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdData,
  output logic              wrapFlag,
  output logic              errPulse,
  output logic [ADDR_W-1:0] rfAddrP,
  input  logic [DATA_W-1:0] rfDataP,
  output logic              rfWriteEnable,
  output logic [ADDR_W-1:0] rfWriteAddr,
  output logic [DATA_W-1:0] rfWriteData
);

  state_t              r_state, w_next;
  logic                r_owner;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;
  logic [DATA_W-1:0]   r_incr;
  logic [DATA_W-1:0]   r_rd;
  logic                r_wrap;
  logic                r_prio;   // requester holding tie priority; 0 after reset

  logic [1:0]          w_grant;
  logic [1:0]          w_sel_op;
  logic                w_sel_err;
  logic [DATA_W:0]     w_sum;
  logic                w_we;
  logic [ADDR_W-1:0]   w_wa;
  logic [DATA_W-1:0]   w_wd;
  logic [1:0]          w_done;
  logic                w_err;

  rr_pick2 u_pick (
    .i_req   (reqValid),
    .i_last  (~r_prio),
    .o_grant (w_grant)
  );

  assign w_sel_op  = w_grant[1] ? reqOp1 : reqOp0;
  assign w_sel_err = w_grant[1] && (reqOp1 == OP_WRITE || reqOp1 == OP_INCR);
  // Carry-out of the +1 is the wrap indication.
  assign w_sum     = {1'b0, rfDataP} + (DATA_W+1)'(1);

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Transaction latch, read result, wrap flag and round-robin pointer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_owner <= 1'b0;
      r_op    <= OP_READ;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_incr  <= '0;
      r_rd    <= '0;
      r_wrap  <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (|w_grant) begin
          r_owner <= w_grant[1];
          r_op    <= norm_op(w_grant[1], w_sel_op);
          r_addr  <= w_grant[1] ? reqAddr1 : reqAddr0;
          r_data  <= w_grant[1] ? reqData1 : reqData0;
          r_err   <= w_sel_err;
        end
        ST_EXEC: begin
          if (r_op == OP_INCR) begin
            r_incr <= w_sum[DATA_W-1:0];
            if (w_sum[DATA_W]) r_wrap <= 1'b1;
          end else if (r_op != OP_WRITE) begin
            r_rd <= rfDataP;
          end
        end
        ST_WB:   r_rd   <= r_incr;
        ST_DONE: r_prio <= ~r_owner;
        default: ;
      endcase
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_wa   = '0;
    w_wd   = '0;
    w_done = 2'b00;
    w_err  = 1'b0;
    case (r_state)
      ST_IDLE: if (|w_grant) w_next = ST_EXEC;
      ST_EXEC: begin
        w_err = r_err;
        if (r_op == OP_INCR) begin
          w_next = ST_WB;
        end else begin
          w_next = ST_DONE;
          if (r_op == OP_WRITE) begin
            w_we = 1'b1;
            w_wa = r_addr;
            w_wd = r_data;
          end
        end
      end
      ST_WB: begin
        w_we   = 1'b1;
        w_wa   = r_addr;
        w_wd   = r_incr;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done[r_owner] = 1'b1;
        w_next          = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Strobes are suppressed while Reset is high so an abandoned transaction never writes.
  assign accept        = (r_state == ST_IDLE && !Reset) ? w_grant : 2'b00;
  assign done          = Reset ? 2'b00 : w_done;
  assign errPulse      = w_err & ~Reset;
  assign rfWriteEnable = w_we & ~Reset;
  assign rfWriteAddr   = w_wa;
  assign rfWriteData   = w_wd;
  assign rfAddrP       = r_addr;
  assign rdData        = r_rd;
  assign wrapFlag      = r_wrap;

endmodule
